// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 32-bit ripple ALU: decodes MIPS funct codes,
// holds registered operands for a settle window, then returns result and flags.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [5:0]       cmd_funct_i,
    input  logic [2:0]       cmd_cmp_i,
    input  logic [31:0]      cmd_src1_i,
    input  logic [31:0]      cmd_src2_i,
    output logic [31:0]      alu_src1_o,
    output logic [31:0]      alu_src2_o,
    output logic [3:0]       alu_ctrl_o,
    output logic [2:0]       alu_bonus_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,
    input  logic             alu_cout_i,
    input  logic             alu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [2:0]       rsp_flags_o,
    output logic             rsp_err_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_NAND = 6'h28;
    localparam logic [5:0] FUNCT_SET  = 6'h2A;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SET  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;

    localparam logic [CNT_W-1:0] COUNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      next_state;
    logic [3:0]  settle_cnt;
    logic        accept;
    logic        legal;
    logic        settle_done;
    logic        rsp_done;
    logic [3:0]  dec_ctrl;
    logic [2:0]  dec_bonus;

    // Only SET forwards the compare selector; every other op drives bonus low.
    always_comb begin
        dec_ctrl  = CTRL_AND;
        dec_bonus = 3'b000;
        legal     = 1'b1;
        case (cmd_funct_i)
            FUNCT_AND:  dec_ctrl = CTRL_AND;
            FUNCT_OR:   dec_ctrl = CTRL_OR;
            FUNCT_ADD:  dec_ctrl = CTRL_ADD;
            FUNCT_SUB:  dec_ctrl = CTRL_SUB;
            FUNCT_NOR:  dec_ctrl = CTRL_NOR;
            FUNCT_NAND: dec_ctrl = CTRL_NAND;
            FUNCT_SET: begin
                dec_ctrl  = CTRL_SET;
                dec_bonus = cmd_cmp_i;
            end
            default:    legal = 1'b0;
        endcase
    end

    assign accept      = cmd_valid_i && cmd_ready_o;
    // Treating a count of 1 (or a stray 0) as the final settle cycle keeps ISSUE from stalling forever.
    assign settle_done = (state == ISSUE) && (settle_cnt <= 4'd1);
    assign rsp_done    = (state == RESP) && rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (settle_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE:    cmd_ready_o = 1'b1;
            RESP:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Illegal commands leave the ALU inputs untouched and go straight to an error response.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            settle_cnt   <= 4'd0;
            alu_src1_o   <= 32'd0;
            alu_src2_o   <= 32'd0;
            alu_ctrl_o   <= CTRL_AND;
            alu_bonus_o  <= 3'b000;
            rsp_result_o <= 32'd0;
            rsp_flags_o  <= 3'b000;
            rsp_err_o    <= 1'b0;
            op_count_o   <= '0;
        end else begin
            if (accept) begin
                if (legal) begin
                    alu_src1_o  <= cmd_src1_i;
                    alu_src2_o  <= cmd_src2_i;
                    alu_ctrl_o  <= dec_ctrl;
                    alu_bonus_o <= dec_bonus;
                    settle_cnt  <= SETTLE_INIT;
                end else begin
                    rsp_result_o <= 32'd0;
                    rsp_flags_o  <= 3'b000;
                    rsp_err_o    <= 1'b1;
                end
            end

            if (state == ISSUE) begin
                settle_cnt <= settle_cnt - 4'd1;
                if (settle_done) begin
                    rsp_result_o <= alu_result_i;
                    rsp_flags_o  <= {alu_overflow_i, alu_cout_i, alu_zero_i};
                    rsp_err_o    <= 1'b0;
                end
            end

            if (rsp_done && !rsp_err_o) begin
                op_count_o <= op_count_o + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: two instances (settle 1 and 3) in front of
// a behavioural ALU, expected responses queued at accept and compared on response.
module tb_alu_cmd_sequencer;

    typedef struct {
        logic [31:0] result;
        logic [2:0]  flags;
        logic        err;
        logic [3:0]  ctrl;
        logic [2:0]  bonus;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [5:0]  cmd_funct = 6'h00;
    logic [2:0]  cmd_cmp = 3'b000;
    logic [31:0] cmd_src1 = 32'd0;
    logic [31:0] cmd_src2 = 32'd0;

    logic        a_cmd_valid, a_cmd_ready, a_alu_zero, a_alu_cout, a_alu_ovf;
    logic        a_rsp_valid, a_rsp_err;
    logic [31:0] a_alu_src1, a_alu_src2, a_alu_result, a_rsp_result;
    logic [3:0]  a_alu_ctrl;
    logic [2:0]  a_alu_bonus, a_rsp_flags;
    logic [15:0] a_op_count;

    logic        b_cmd_valid, b_cmd_ready, b_alu_zero, b_alu_cout, b_alu_ovf;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_alu_src1, b_alu_src2, b_alu_result, b_rsp_result;
    logic [3:0]  b_alu_ctrl;
    logic [2:0]  b_alu_bonus, b_rsp_flags;
    logic [15:0] b_op_count;

    exp_t        sb[$];
    int          checkCount = 0;
    int          passCount = 0;
    logic [15:0] expCount[2] = '{16'd0, 16'd0};
    logic [3:0]  lastCtrl[2] = '{4'd0, 4'd0};
    logic [2:0]  lastBonus[2] = '{3'd0, 3'd0};
    int          settle[2] = '{1, 3};
    logic [5:0]  functs[6] = '{6'h24, 6'h25, 6'h27, 6'h28, 6'h20, 6'h22};

    always #5 clk = ~clk;

    assign a_cmd_valid = cmd_valid & ~sel;
    assign b_cmd_valid = cmd_valid & sel;

    alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_n(rst_n),
        .cmd_valid_i(a_cmd_valid), .cmd_ready_o(a_cmd_ready),
        .cmd_funct_i(cmd_funct), .cmd_cmp_i(cmd_cmp),
        .cmd_src1_i(cmd_src1), .cmd_src2_i(cmd_src2),
        .alu_src1_o(a_alu_src1), .alu_src2_o(a_alu_src2),
        .alu_ctrl_o(a_alu_ctrl), .alu_bonus_o(a_alu_bonus),
        .alu_result_i(a_alu_result), .alu_zero_i(a_alu_zero),
        .alu_cout_i(a_alu_cout), .alu_overflow_i(a_alu_ovf),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(a_rsp_result), .rsp_flags_o(a_rsp_flags),
        .rsp_err_o(a_rsp_err), .op_count_o(a_op_count)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(3), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_n(rst_n),
        .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
        .cmd_funct_i(cmd_funct), .cmd_cmp_i(cmd_cmp),
        .cmd_src1_i(cmd_src1), .cmd_src2_i(cmd_src2),
        .alu_src1_o(b_alu_src1), .alu_src2_o(b_alu_src2),
        .alu_ctrl_o(b_alu_ctrl), .alu_bonus_o(b_alu_bonus),
        .alu_result_i(b_alu_result), .alu_zero_i(b_alu_zero),
        .alu_cout_i(b_alu_cout), .alu_overflow_i(b_alu_ovf),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(b_rsp_result), .rsp_flags_o(b_rsp_flags),
        .rsp_err_o(b_rsp_err), .op_count_o(b_op_count)
    );

    // Behavioural ALU returning {overflow, cout, zero, result}.
    function automatic logic [34:0] aluModel(input logic [3:0] ctrl, input logic [2:0] bonus,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        logic [32:0] diff;
        logic [31:0] r;
        logic        c;
        logic        v;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (ctrl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r = sum[31:0];
                c = sum[32];
                v = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            4'b0110: begin
                r = diff[31:0];
                c = diff[32];
                v = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
            4'b0111: begin
                c = diff[32];
                v = (a[31] != b[31]) && (diff[31] != a[31]);
                case (bonus)
                    3'b000:  r = {31'd0, $signed(a) <  $signed(b)};
                    3'b001:  r = {31'd0, $signed(a) >  $signed(b)};
                    3'b010:  r = {31'd0, $signed(a) <= $signed(b)};
                    3'b011:  r = {31'd0, $signed(a) >= $signed(b)};
                    3'b100:  r = {31'd0, a == b};
                    3'b101:  r = {31'd0, a != b};
                    default: r = 32'd0;
                endcase
            end
            default: r = 32'd0;
        endcase
        return {v, c, (r == 32'd0), r};
    endfunction

    always_comb {a_alu_ovf, a_alu_cout, a_alu_zero, a_alu_result} = aluModel(a_alu_ctrl, a_alu_bonus, a_alu_src1, a_alu_src2);
    always_comb {b_alu_ovf, b_alu_cout, b_alu_zero, b_alu_result} = aluModel(b_alu_ctrl, b_alu_bonus, b_alu_src1, b_alu_src2);

    function automatic logic decodeFunct(input logic [5:0] f, output logic [3:0] ctrl);
        ctrl = 4'b0000;
        case (f)
            6'h24: ctrl = 4'b0000;
            6'h25: ctrl = 4'b0001;
            6'h20: ctrl = 4'b0010;
            6'h22: ctrl = 4'b0110;
            6'h27: ctrl = 4'b1100;
            6'h28: ctrl = 4'b1101;
            6'h2A: ctrl = 4'b0111;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic vCmdReady();  return sel ? b_cmd_ready : a_cmd_ready;  endfunction
    function automatic logic vRspValid();  return sel ? b_rsp_valid : a_rsp_valid;  endfunction
    function automatic logic [31:0] vResult(); return sel ? b_rsp_result : a_rsp_result; endfunction
    function automatic logic [2:0] vFlags();  return sel ? b_rsp_flags : a_rsp_flags;  endfunction
    function automatic logic vErr();       return sel ? b_rsp_err : a_rsp_err;      endfunction
    function automatic logic [3:0] vCtrl();   return sel ? b_alu_ctrl : a_alu_ctrl;    endfunction
    function automatic logic [2:0] vBonus();  return sel ? b_alu_bonus : a_alu_bonus;  endfunction
    function automatic logic [15:0] vCount(); return sel ? b_op_count : a_op_count;    endfunction

    // Drives one command to the selected instance and queues its expected response at accept.
    task automatic applyStimulus(input logic [5:0] f, input logic [2:0] cmp,
                                 input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [3:0]  ctrl;
        logic        ok;
        logic [34:0] m;
        ok = decodeFunct(f, ctrl);
        if (ok) begin
            e.bonus  = (f == 6'h2A) ? cmp : 3'b000;
            m        = aluModel(ctrl, e.bonus, a, b);
            e.result = m[31:0];
            e.flags  = m[34:32];
            e.err    = 1'b0;
            e.ctrl   = ctrl;
            e.lat    = settle[sel];
        end else begin
            e.result = 32'd0;
            e.flags  = 3'b000;
            e.err    = 1'b1;
            e.ctrl   = lastCtrl[sel];
            e.bonus  = lastBonus[sel];
            e.lat    = 0;
        end
        @(negedge clk);
        cmd_funct = f;
        cmd_cmp   = cmp;
        cmd_src1  = a;
        cmd_src2  = b;
        cmd_valid = 1'b1;
        checkOutput("cmd_ready_before_accept", 32'(vCmdReady()), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_funct = 6'($urandom);
        cmd_src1  = $urandom;
        cmd_src2  = $urandom;
        sb.push_back(e);
        if (ok) begin
            lastCtrl[sel]  = e.ctrl;
            lastBonus[sel] = e.bonus;
        end
    endtask

    // Waits for the response, compares against the queue head, optionally stalls, then handshakes.
    task automatic collectResponse(input int hold, input logic pulse);
        exp_t e;
        int   cycles = 0;
        while (!vRspValid() && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        checkOutput("rsp_latency", 32'(cycles), 32'(e.lat));
        checkOutput("rsp_valid", 32'(vRspValid()), 32'd1);
        checkOutput("rsp_result", vResult(), e.result);
        checkOutput("rsp_flags", 32'(vFlags()), 32'(e.flags));
        checkOutput("rsp_err", 32'(vErr()), 32'(e.err));
        checkOutput("alu_ctrl", 32'(vCtrl()), 32'(e.ctrl));
        checkOutput("alu_bonus", 32'(vBonus()), 32'(e.bonus));
        checkOutput("cmd_ready_in_resp", 32'(vCmdReady()), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                cmd_funct = 6'h25;
                cmd_src1  = 32'hDEADBEEF;
                cmd_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            checkOutput("stall_valid", 32'(vRspValid()), 32'd1);
            checkOutput("stall_result", vResult(), e.result);
            checkOutput("stall_flags", 32'(vFlags()), 32'(e.flags));
            checkOutput("stall_cmd_ready", 32'(vCmdReady()), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (!e.err) expCount[sel] = expCount[sel] + 16'd1;
        checkOutput("rsp_valid_drop", 32'(vRspValid()), 32'd0);
        checkOutput("cmd_ready_back", 32'(vCmdReady()), 32'd1);
        checkOutput("op_count", 32'(vCount()), 32'(expCount[sel]));
        checkOutput("rsp_held_after", vResult(), e.result);
    endtask

    task automatic checkResetState();
        checkOutput("rst_a_cmd_ready", 32'(a_cmd_ready), 32'd1);
        checkOutput("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        checkOutput("rst_a_alu", {a_alu_src1 | a_alu_src2}, 32'd0);
        checkOutput("rst_a_ctrl", 32'({a_alu_ctrl, a_alu_bonus}), 32'd0);
        checkOutput("rst_a_rsp", a_rsp_result, 32'd0);
        checkOutput("rst_a_flags_err", 32'({a_rsp_flags, a_rsp_err}), 32'd0);
        checkOutput("rst_a_count", 32'(a_op_count), 32'd0);
        checkOutput("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd1);
        checkOutput("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        checkOutput("rst_b_alu", {b_alu_src1 | b_alu_src2}, 32'd0);
        checkOutput("rst_b_ctrl", 32'({b_alu_ctrl, b_alu_bonus}), 32'd0);
        checkOutput("rst_b_rsp", 32'({b_rsp_result[28:0], b_rsp_flags}) | 32'(b_rsp_err), 32'd0);
        checkOutput("rst_b_count", 32'(b_op_count), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rogue;
        $display("[TB] starting alu_cmd_sequencer bench");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState();
        rst_n = 1'b1;

        sel = 1'b0;
        applyStimulus(6'h20, 3'b000, 32'h7FFFFFFF, 32'h00000001);
        collectResponse(0, 1'b0);
        checkOutput("add_const_result", a_rsp_result, 32'h80000000);
        checkOutput("add_const_flags", 32'(a_rsp_flags), 32'b100);

        applyStimulus(6'h22, 3'b000, 32'h12345678, 32'h12345678);
        collectResponse(0, 1'b0);
        checkOutput("sub_eq_flags", 32'(a_rsp_flags), 32'b011);

        applyStimulus(6'h2A, 3'b000, 32'hFFFFFFFF, 32'h00000001);
        collectResponse(0, 1'b0);
        checkOutput("set_lt_result", a_rsp_result, 32'h00000001);

        applyStimulus(6'h2A, 3'b100, 32'h00000005, 32'h00000005);
        collectResponse(0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(functs[i], 3'($urandom_range(0, 7)), $urandom, $urandom);
            collectResponse(0, 1'b0);
        end

        applyStimulus(6'h3F, 3'b000, 32'hAAAA5555, 32'h5555AAAA);
        collectResponse(0, 1'b0);
        applyStimulus(6'h00, 3'b011, 32'h1, 32'h2);
        collectResponse(0, 1'b0);
        applyStimulus(6'h25, 3'b000, 32'hF0F00000, 32'h00000F0F);
        collectResponse(0, 1'b0);

        sel = 1'b1;
        applyStimulus(6'h20, 3'b000, 32'hFFFFFFFF, 32'h00000001);
        collectResponse(5, 1'b1);
        rogue = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (b_rsp_valid || !b_cmd_ready) rogue++;
        end
        checkOutput("stall_pulse_ignored", 32'(rogue), 32'd0);
        checkOutput("stall_pulse_count", 32'(b_op_count), 32'd1);

        applyStimulus(6'h22, 3'b000, 32'h00000010, 32'h00000020);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetState();
        rst_n = 1'b1;
        sb.delete();
        expCount  = '{16'd0, 16'd0};
        lastCtrl  = '{4'd0, 4'd0};
        lastBonus = '{3'd0, 3'd0};
        rogue = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (b_rsp_valid) rogue++;
        end
        checkOutput("midreset_no_rsp", 32'(rogue), 32'd0);

        applyStimulus(6'h28, 3'b000, 32'h0000FFFF, 32'h00FF00FF);
        collectResponse(2, 1'b0);
        sel = 1'b0;
        applyStimulus(6'h24, 3'b000, 32'hFF00FF00, 32'h0FF00FF0);
        collectResponse(0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
